// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE read-data collection path.
package pe_pkg;
   localparam int WID_BUS_DEF   = 32;
   localparam int MAX_BEATS_DEF = 64;

   typedef struct packed {
      logic                   last;
      logic [WID_BUS_DEF-1:0] data;
   } beat_t;
endpackage

// File: rtl/pe_rdata_collector_if.sv
// Read-data stream from pe_cell plus the buffered valid/ready stream toward the host.
interface pe_rdata_collector_if #(
   parameter int WID_BUS = pe_pkg::WID_BUS_DEF
) ();
   logic [WID_BUS-1:0] rdata;
   logic               rdata_valid;
   logic               rdata_last;
   logic               rdata_busy;
   logic [WID_BUS-1:0] m_data;
   logic               m_valid;
   logic               m_last;
   logic               m_ready;

   // master: the surrounding system (pe_cell producer and host consumer)
   modport master (
      output rdata, rdata_valid, rdata_last, m_ready,
      input  rdata_busy, m_data, m_valid, m_last
   );

   // slave: the collector itself
   modport slave (
      input  rdata, rdata_valid, rdata_last, m_ready,
      output rdata_busy, m_data, m_valid, m_last
   );
endinterface

// File: rtl/pe_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full flag and occupancy count.
module pe_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, full_d;
   logic             wr_en, rd_en;

   assign wr_en = push && !full_q;
   assign rd_en = pop && (level_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      full_d = (level_d == LW'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
      end
   end

   // Storage carries no reset; stale entries are hidden by the empty mask below.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = (level_q == '0);
   assign level = level_q;
endmodule

// File: rtl/pe_rdata_collector.sv
// Buffers the pe_cell read-data stream, enforces a maximum frame length and counts emitted frames.
module pe_rdata_collector
   import pe_pkg::*;
#(
   parameter int WID_BUS   = WID_BUS_DEF,
   parameter int DEPTH     = 16,
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int WID_FCNT  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   pe_rdata_collector_if.slave    bus,
   output logic [WID_FCNT-1:0]    frame_cnt,
   output logic                   len_err,
   input  logic                   clr_err,
   output logic [$clog2(DEPTH):0] fifo_level
);
   logic [WID_BUS:0]      head;
   logic                  fifo_full, fifo_empty;
   logic                  push, pop, tag_last, forced;
   logic [15:0]           beat_cnt_q, beat_cnt_d;
   logic [WID_FCNT-1:0]   frame_cnt_q, frame_cnt_d;
   logic                  len_err_q, len_err_d;

   assign push     = bus.rdata_valid && !fifo_full;
   assign pop      = !fifo_empty && bus.m_ready;
   assign tag_last = bus.rdata_last || (beat_cnt_q == 16'(MAX_BEATS - 1));
   assign forced   = tag_last && !bus.rdata_last;

   pe_sync_fifo #(
      .WIDTH (WID_BUS + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({tag_last, bus.rdata}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      frame_cnt_d = frame_cnt_q;
      len_err_d   = len_err_q;
      if (push) beat_cnt_d = tag_last ? 16'd0 : beat_cnt_q + 16'd1;
      if (pop && head[WID_BUS]) frame_cnt_d = frame_cnt_q + 1'b1;
      // A forced termination outranks a clear landing on the same edge.
      if (push && forced)  len_err_d = 1'b1;
      else if (clr_err)    len_err_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
         len_err_q   <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         len_err_q   <= len_err_d;
      end
   end

   assign bus.rdata_busy = fifo_full;
   assign bus.m_valid    = !fifo_empty;
   assign bus.m_data     = head[WID_BUS-1:0];
   assign bus.m_last     = head[WID_BUS];
   assign frame_cnt      = frame_cnt_q;
   assign len_err        = len_err_q;
endmodule

// File: tb/tb_pe_rdata_collector.sv
// Scoreboard bench for pe_rdata_collector: directed streams, monitor checks every output cycle.
module tb_pe_rdata_collector;
   import pe_pkg::*;

   localparam int DEPTH = 16;
   localparam int MAXB  = 4;
   localparam int WFC   = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           clr_err = 1'b0;
   logic [WFC-1:0] frame_cnt;
   logic           len_err;
   logic [LW-1:0]  fifo_level;

   pe_rdata_collector_if #(.WID_BUS(32)) bus ();

   pe_rdata_collector #(
      .WID_BUS   (32),
      .DEPTH     (DEPTH),
      .MAX_BEATS (MAXB),
      .WID_FCNT  (WFC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .frame_cnt  (frame_cnt),
      .len_err    (len_err),
      .clr_err    (clr_err),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state, updated for the edge that follows each negedge.
   beat_t          exp_q[$];
   beat_t          e;
   int             m_level = 0;
   int             m_bcnt = 0;
   logic [WFC-1:0] m_fcnt = '0;
   logic           m_lerr = 1'b0;
   logic           tag, frc;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_level = 0;
         m_bcnt  = 0;
         m_fcnt  = '0;
         m_lerr  = 1'b0;
      end else begin
         chk("level", 64'(fifo_level), 64'(m_level));
         chk("busy", 64'(bus.rdata_busy), 64'(m_level == DEPTH));
         chk("m_valid", 64'(bus.m_valid), 64'(m_level != 0));
         chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
         chk("len_err", 64'(len_err), 64'(m_lerr));
         if (m_level == 0) chk("m_data_mask", 64'(bus.m_data), 64'd0);
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               $display("pop  data=%08h last=%0b (exp %08h/%0b)", bus.m_data, bus.m_last, e.data, e.last);
               chk("m_data", 64'(bus.m_data), 64'(e.data));
               chk("m_last", 64'(bus.m_last), 64'(e.last));
               if (e.last) m_fcnt = m_fcnt + 1'b1;
               m_level--;
            end
         end
         if (bus.rdata_valid && !bus.rdata_busy) begin
            tag = bus.rdata_last || (m_bcnt == MAXB - 1);
            frc = tag && !bus.rdata_last;
            exp_q.push_back('{last: tag, data: bus.rdata});
            m_level++;
            m_bcnt = tag ? 0 : m_bcnt + 1;
            if (frc) m_lerr = 1'b1;
            else if (clr_err) m_lerr = 1'b0;
         end else if (clr_err) begin
            m_lerr = 1'b0;
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic l, input logic clr = 1'b0);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      bus.rdata       = d;
      bus.rdata_last  = l;
      bus.rdata_valid = 1'b1;
      clr_err         = clr;
      while (!acc) begin
         @(negedge clk);
         acc = !bus.rdata_busy;
         @(posedge clk);
         #1;
         clr_err = 1'b0;
         if (!acc) begin
            n++;
            if (n > 200) begin
               checks++;
               errors++;
               $display("FAIL send_timeout: beat %08h still blocked after %0d cycles", d, n);
               acc = 1'b1;
            end
         end
      end
      bus.rdata_valid = 1'b0;
      bus.rdata_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.m_ready = 1'b1;
      while (bus.m_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      bus.rdata       = '0;
      bus.rdata_valid = 1'b0;
      bus.rdata_last  = 1'b0;
      bus.m_ready     = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_busy", 64'(bus.rdata_busy), 64'd0);
      chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_m_last", 64'(bus.m_last), 64'd0);
      chk("rst_m_data", 64'(bus.m_data), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_len_err", 64'(len_err), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Pass-through: each beat visible the cycle after its push.
      bus.m_ready = 1'b1;
      send(32'hA1, 1'b0);
      chk("pt_a1", 64'(bus.m_data), 64'hA1);
      send(32'hA2, 1'b0);
      chk("pt_a2", 64'(bus.m_data), 64'hA2);
      send(32'hA3, 1'b1);
      chk("pt_a3", 64'(bus.m_data), 64'hA3);
      chk("pt_a3_last", 64'(bus.m_last), 64'd1);
      drain();
      chk("pt_frames", 64'(frame_cnt), 64'd1);

      // Fill and backpressure.
      bus.m_ready = 1'b0;
      fork
         for (int i = 0; i < 20; i++) send(32'h100 + 32'(i), 1'b0);
         begin
            repeat (18) @(posedge clk);
            #1;
            chk("fill_busy", 64'(bus.rdata_busy), 64'd1);
            chk("fill_level", 64'(fifo_level), 64'd16);
            bus.m_ready = 1'b1;
            @(posedge clk);
            #1 bus.m_ready = 1'b0;
            chk("fill_busy_drop", 64'(bus.rdata_busy), 64'd0);
            @(posedge clk);
            #1;
            chk("fill_beat17", 64'(bus.rdata_busy), 64'd1);
            repeat (2) @(posedge clk);
            #1 bus.m_ready = 1'b1;
         end
      join
      drain();

      // Simultaneous push/pop at level 8.
      bus.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(32'h200 + 32'(i), 1'b0);
      bus.m_ready = 1'b1;
      fork
         for (int i = 8; i < 18; i++) send(32'h200 + 32'(i), 1'b0);
         begin
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               chk("pp_level", 64'(fifo_level), 64'd8);
            end
         end
      join
      drain();

      // Length policing with MAX_BEATS=4.
      do_reset();
      bus.m_ready = 1'b1;
      for (int i = 1; i <= 5; i++) send(32'hB0 + 32'(i), 1'b0);
      send(32'hB6, 1'b1);
      drain();
      chk("len_frames", 64'(frame_cnt), 64'd2);
      chk("len_err_set", 64'(len_err), 64'd1);
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      chk("len_err_clr", 64'(len_err), 64'd0);
      for (int i = 0; i < 3; i++) send(32'hC0 + 32'(i), 1'b0);
      send(32'hC3, 1'b0, 1'b1);
      chk("len_err_prio", 64'(len_err), 64'd1);
      drain();
      chk("len_frames2", 64'(frame_cnt), 64'd3);

      // Frame counter wrap and pointer wrap.
      do_reset();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 17; i++) send(32'hD00 + 32'(i), 1'b1);
      drain();
      chk("wrap_frames", 64'(frame_cnt), 64'd1);

      // Asynchronous reset with beats buffered.
      bus.m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(32'hE0 + 32'(i), 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("arst_busy", 64'(bus.rdata_busy), 64'd0);
      chk("arst_level", 64'(fifo_level), 64'd0);
      chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("arst_hold_level", 64'(fifo_level), 64'd0);
      chk("arst_hold_valid", 64'(bus.m_valid), 64'd0);
      rst = 1'b0;
      bus.m_ready = 1'b1;
      send(32'hF1, 1'b0);
      send(32'hF2, 1'b0);
      send(32'hF3, 1'b0);
      send(32'hF4, 1'b0);
      drain();
      chk("arst_new_frame", 64'(frame_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
